// File: rtl/rv32_hazard_ctrl.sv
// Hazard, forwarding and freeze controller for the rv32 five-stage pipeline.
// Stall/bubble/flush/forward decisions are combinational; only perf counters and the watchdog are registered.
module rv32_hazard_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned FWD_EN   = 1,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_SRC*REG_AW-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]          id_rs_used,
    input  logic [REG_AW-1:0]           id_ex_rd,
    input  logic [REG_AW-1:0]           ex_mem_rd,
    input  logic [REG_AW-1:0]           mem_wb_rd,
    input  logic                        id_ex_regwrite,
    input  logic                        ex_mem_regwrite,
    input  logic                        mem_wb_regwrite,
    input  logic                        id_ex_mem_read,
    input  logic                        ex_mem_mem_read,
    input  logic                        ex_busy,
    input  logic                        dmem_stall,
    input  logic                        ex_redirect,
    output logic                        pc_stall,
    output logic                        if_id_stall,
    output logic                        id_ex_stall,
    output logic                        ex_mem_stall,
    output logic                        if_id_flush,
    output logic                        id_ex_bubble,
    output logic                        ex_mem_bubble,
    output logic                        mem_wb_bubble,
    output logic [2*NUM_SRC-1:0]        forward_sel,
    output logic [2:0]                  hz_reason,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            flush_cnt,
    output logic                        hang_err
);

    typedef enum logic [2:0] {
        HZ_RUN   = 3'd0,
        HZ_DATA  = 3'd1,
        HZ_FLUSH = 3'd2,
        HZ_BUSY  = 3'd3,
        HZ_MEM   = 3'd4
    } hz_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_MEM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_e;

    localparam int unsigned FZ_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [FZ_W-1:0] FZ_MAX = FZ_W'(TIMEOUT);

    logic [NUM_SRC-1:0] m_ex;
    logic [NUM_SRC-1:0] m_mem;
    logic [NUM_SRC-1:0] src_haz;
    logic               data_haz;
    logic               freeze;
    hz_e                hz;
    logic [FZ_W-1:0]    fz_cnt;
    logic [FZ_W-1:0]    fz_nxt;

    // The register file is write-through, so a mem_wb producer never needs a bypass.
    logic unused_wb;
    assign unused_wb = ^{mem_wb_rd, mem_wb_regwrite};

    // Per-source producer matching, RAW hazard detection and bypass selection.
    always_comb begin
        logic [REG_AW-1:0] rs;
        logic              live;
        rs          = '0;
        live        = 1'b0;
        m_ex        = '0;
        m_mem       = '0;
        src_haz     = '0;
        forward_sel = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            rs       = id_rs[k*REG_AW +: REG_AW];
            live     = id_rs_used[k] && (rs != '0);
            m_ex[k]  = live && id_ex_regwrite  && (rs == id_ex_rd);
            m_mem[k] = live && ex_mem_regwrite && (rs == ex_mem_rd);
            if (FWD_EN != 0) begin
                src_haz[k] = (m_ex[k] && id_ex_mem_read) ||
                             ((LOAD_LAT >= 2) && m_mem[k] && ex_mem_mem_read);
            end else begin
                src_haz[k] = m_ex[k] || m_mem[k];
            end
            forward_sel[2*k +: 2] = FWD_NONE;
            if ((FWD_EN != 0) && !src_haz[k]) begin
                if (m_ex[k]) begin
                    forward_sel[2*k +: 2] = FWD_MEM;
                end else if (m_mem[k]) begin
                    forward_sel[2*k +: 2] = FWD_WB;
                end
            end
        end
    end

    assign data_haz = |src_haz;
    assign freeze   = dmem_stall | ex_busy;

    // Freezes outrank a redirect: EX is held, so the redirect is seen again once unfrozen.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        mem_wb_bubble = 1'b0;
        hz            = HZ_RUN;
        if (dmem_stall) begin
            hz            = HZ_MEM;
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (ex_busy) begin
            hz            = HZ_BUSY;
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (ex_redirect) begin
            hz            = HZ_FLUSH;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
        end else if (data_haz) begin
            hz            = HZ_DATA;
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_bubble  = 1'b1;
        end
    end

    assign hz_reason = hz;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (if_id_flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        fz_nxt = '0;
        if ((TIMEOUT != 0) && freeze) begin
            fz_nxt = (fz_cnt == FZ_MAX) ? fz_cnt : fz_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fz_cnt   <= '0;
            hang_err <= 1'b0;
        end else begin
            fz_cnt <= fz_nxt;
            if ((TIMEOUT != 0) && freeze && (fz_nxt == FZ_MAX)) begin
                hang_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Bench for rv32_hazard_ctrl: three configurations share one stimulus stream and
// are checked against a distance-based hazard model and counting reference.
module tb_rv32_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [4:0]  id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic        id_ex_regwrite, ex_mem_regwrite, mem_wb_regwrite;
    logic        id_ex_mem_read, ex_mem_mem_read;
    logic        ex_busy, dmem_stall, ex_redirect;

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // a: FWD_EN=1 LOAD_LAT=1 TIMEOUT=4; b: LOAD_LAT=2 TIMEOUT=8; c: FWD_EN=0 CNT_W=4 TIMEOUT=0
    logic a_pc_stall, a_if_id_stall, a_id_ex_stall, a_ex_mem_stall, a_if_id_flush;
    logic a_id_ex_bubble, a_ex_mem_bubble, a_mem_wb_bubble, a_hang_err;
    logic [3:0]  a_fwd;
    logic [2:0]  a_hz;
    logic [31:0] a_stall_cnt, a_flush_cnt;
    logic b_pc_stall, b_if_id_stall, b_id_ex_stall, b_ex_mem_stall, b_if_id_flush;
    logic b_id_ex_bubble, b_ex_mem_bubble, b_mem_wb_bubble, b_hang_err;
    logic [3:0]  b_fwd;
    logic [2:0]  b_hz;
    logic [31:0] b_stall_cnt, b_flush_cnt;
    logic c_pc_stall, c_if_id_stall, c_id_ex_stall, c_ex_mem_stall, c_if_id_flush;
    logic c_id_ex_bubble, c_ex_mem_bubble, c_mem_wb_bubble, c_hang_err;
    logic [3:0]  c_fwd;
    logic [2:0]  c_hz;
    logic [3:0]  c_stall_cnt, c_flush_cnt;

    rv32_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .FWD_EN(1), .LOAD_LAT(1), .CNT_W(32), .TIMEOUT(4)) u_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .id_ex_regwrite(id_ex_regwrite), .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
        .id_ex_mem_read(id_ex_mem_read), .ex_mem_mem_read(ex_mem_mem_read),
        .ex_busy(ex_busy), .dmem_stall(dmem_stall), .ex_redirect(ex_redirect),
        .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall), .id_ex_stall(a_id_ex_stall), .ex_mem_stall(a_ex_mem_stall),
        .if_id_flush(a_if_id_flush), .id_ex_bubble(a_id_ex_bubble), .ex_mem_bubble(a_ex_mem_bubble),
        .mem_wb_bubble(a_mem_wb_bubble), .forward_sel(a_fwd), .hz_reason(a_hz),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt), .hang_err(a_hang_err));

    rv32_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .FWD_EN(1), .LOAD_LAT(2), .CNT_W(32), .TIMEOUT(8)) u_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .id_ex_regwrite(id_ex_regwrite), .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
        .id_ex_mem_read(id_ex_mem_read), .ex_mem_mem_read(ex_mem_mem_read),
        .ex_busy(ex_busy), .dmem_stall(dmem_stall), .ex_redirect(ex_redirect),
        .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall), .id_ex_stall(b_id_ex_stall), .ex_mem_stall(b_ex_mem_stall),
        .if_id_flush(b_if_id_flush), .id_ex_bubble(b_id_ex_bubble), .ex_mem_bubble(b_ex_mem_bubble),
        .mem_wb_bubble(b_mem_wb_bubble), .forward_sel(b_fwd), .hz_reason(b_hz),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .hang_err(b_hang_err));

    rv32_hazard_ctrl #(.REG_AW(5), .NUM_SRC(2), .FWD_EN(0), .LOAD_LAT(1), .CNT_W(4), .TIMEOUT(0)) u_c (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .id_ex_regwrite(id_ex_regwrite), .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_regwrite(mem_wb_regwrite),
        .id_ex_mem_read(id_ex_mem_read), .ex_mem_mem_read(ex_mem_mem_read),
        .ex_busy(ex_busy), .dmem_stall(dmem_stall), .ex_redirect(ex_redirect),
        .pc_stall(c_pc_stall), .if_id_stall(c_if_id_stall), .id_ex_stall(c_id_ex_stall), .ex_mem_stall(c_ex_mem_stall),
        .if_id_flush(c_if_id_flush), .id_ex_bubble(c_id_ex_bubble), .ex_mem_bubble(c_ex_mem_bubble),
        .mem_wb_bubble(c_mem_wb_bubble), .forward_sel(c_fwd), .hz_reason(c_hz),
        .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt), .hang_err(c_hang_err));

    logic [14:0] a_comb, b_comb, c_comb;
    assign a_comb = {a_pc_stall, a_if_id_stall, a_id_ex_stall, a_ex_mem_stall, a_if_id_flush,
                     a_id_ex_bubble, a_ex_mem_bubble, a_mem_wb_bubble, a_fwd, a_hz};
    assign b_comb = {b_pc_stall, b_if_id_stall, b_id_ex_stall, b_ex_mem_stall, b_if_id_flush,
                     b_id_ex_bubble, b_ex_mem_bubble, b_mem_wb_bubble, b_fwd, b_hz};
    assign c_comb = {c_pc_stall, c_if_id_stall, c_id_ex_stall, c_ex_mem_stall, c_if_id_flush,
                     c_id_ex_bubble, c_ex_mem_bubble, c_mem_wb_bubble, c_fwd, c_hz};

    // Reference: a producer d stages ahead (1=id_ex, 2=ex_mem, 3=mem_wb) is usable once
    // d reaches the distance its result needs; bypass picks the nearest producer.
    function automatic logic [14:0] exp_comb(input bit fwd, input int lat);
        logic [3:0] fs;
        logic [4:0] rs;
        logic [2:0] why;
        bit m1, m2, sh, any_haz;
        bit pc, ii, ie, em, fl, b1, b2, b3;
        int need1, need2;
        fs = '0; any_haz = 0; why = 3'd0;
        {pc, ii, ie, em, fl, b1, b2, b3} = '0;
        need1 = !fwd ? 3 : (id_ex_mem_read  ? 1 + lat : 1);
        need2 = !fwd ? 3 : (ex_mem_mem_read ? 1 + lat : 1);
        for (int k = 0; k < 2; k++) begin
            rs = id_rs[k*5 +: 5];
            m1 = id_rs_used[k] && rs != 0 && id_ex_regwrite  && rs == id_ex_rd;
            m2 = id_rs_used[k] && rs != 0 && ex_mem_regwrite && rs == ex_mem_rd;
            sh = (m1 && 1 < need1) || (m2 && 2 < need2);
            any_haz = any_haz | sh;
            if (fwd && !sh) fs[k*2 +: 2] = m1 ? 2'b01 : (m2 ? 2'b10 : 2'b00);
        end
        if (dmem_stall) begin pc = 1; ii = 1; ie = 1; em = 1; b3 = 1; why = 3'd4; end
        else if (ex_busy) begin pc = 1; ii = 1; ie = 1; b2 = 1; why = 3'd3; end
        else if (ex_redirect) begin fl = 1; b1 = 1; why = 3'd2; end
        else if (any_haz) begin pc = 1; ii = 1; b1 = 1; why = 3'd1; end
        return {pc, ii, ie, em, fl, b1, b2, b3, fs, why};
    endfunction

    bit          fwd_c [3] = '{1'b1, 1'b1, 1'b0};
    int          lat_c [3] = '{1, 2, 1};
    int          to_c  [3] = '{4, 8, 0};
    logic [63:0] max_c [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hF};
    logic [14:0] exp_v [3];
    logic [63:0] stall_m [3], flush_m [3], run_m [3];
    bit          hang_m [3];

    always_comb begin
        for (int i = 0; i < 3; i++) exp_v[i] = exp_comb(fwd_c[i], lat_c[i]);
    end

    // run_m counts consecutive frozen cycles; hang when the run length hits the timeout.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                stall_m[i] <= '0; flush_m[i] <= '0; run_m[i] <= '0; hang_m[i] <= 1'b0;
            end else begin
                if (exp_v[i][14] && stall_m[i] != max_c[i]) stall_m[i] <= stall_m[i] + 1;
                if (exp_v[i][10] && flush_m[i] != max_c[i]) flush_m[i] <= flush_m[i] + 1;
                if (dmem_stall || ex_busy) begin
                    run_m[i] <= run_m[i] + 1;
                    if (to_c[i] != 0 && run_m[i] + 1 >= to_c[i]) hang_m[i] <= 1'b1;
                end else begin
                    run_m[i] <= '0;
                end
            end
        end
    end

    task automatic clear_inputs();
        id_rs = '0; id_rs_used = '0;
        id_ex_rd = '0; ex_mem_rd = '0; mem_wb_rd = '0;
        id_ex_regwrite = 0; ex_mem_regwrite = 0; mem_wb_regwrite = 0;
        id_ex_mem_read = 0; ex_mem_mem_read = 0;
        ex_busy = 0; dmem_stall = 0; ex_redirect = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; dmem_stall = 1; ex_busy = 1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({a_stall_cnt, a_flush_cnt, a_hang_err} !== 65'd0) begin
            bad++; $display("FAIL reset_a_regs got=%h exp=0", {a_stall_cnt, a_flush_cnt, a_hang_err});
        end
        total++;
        if ({c_stall_cnt, c_flush_cnt, c_hang_err, b_hang_err} !== 10'd0) begin
            bad++; $display("FAIL reset_bc_regs got=%h exp=0", {c_stall_cnt, c_flush_cnt, c_hang_err, b_hang_err});
        end
        total++;
        if ({a_hz, a_pc_stall, a_ex_mem_stall, a_mem_wb_bubble} !== {3'd4, 3'b111}) begin
            bad++; $display("FAIL reset_comb_live got=%b exp=%b", {a_hz, a_pc_stall, a_ex_mem_stall, a_mem_wb_bubble}, {3'd4, 3'b111});
        end
        @(negedge clk);
        clear_inputs();
        rst = 0;
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        id_ex_rd = 5; id_ex_regwrite = 1; id_ex_mem_read = 1;
        id_rs = {5'd0, 5'd5}; id_rs_used = 2'b01;
        #1;
        total++;
        if ({a_hz, a_pc_stall, a_id_ex_bubble, b_hz, c_hz} !== {3'd1, 2'b11, 3'd1, 3'd1}) begin
            bad++; $display("FAIL load_use_c1 got=%b exp=%b", {a_hz, a_pc_stall, a_id_ex_bubble, b_hz, c_hz}, {3'd1, 2'b11, 3'd1, 3'd1});
        end
        @(negedge clk);
        id_ex_rd = 0; id_ex_regwrite = 0; id_ex_mem_read = 0;
        ex_mem_rd = 5; ex_mem_regwrite = 1; ex_mem_mem_read = 1;
        #1;
        total++;
        if ({a_fwd[1:0], a_pc_stall, a_hz} !== {2'b10, 1'b0, 3'd0} || a_stall_cnt !== 32'd1) begin
            bad++; $display("FAIL load_use_lat1_c2 got=%b/%0d exp=%b/1", {a_fwd[1:0], a_pc_stall, a_hz}, a_stall_cnt, {2'b10, 1'b0, 3'd0});
        end
        total++;
        if ({b_hz, b_fwd, b_pc_stall} !== {3'd1, 4'b0000, 1'b1} || b_stall_cnt !== 32'd1) begin
            bad++; $display("FAIL load_use_lat2_c2 got=%b/%0d exp=%b/1", {b_hz, b_fwd, b_pc_stall}, b_stall_cnt, {3'd1, 4'b0000, 1'b1});
        end
        @(negedge clk);
        ex_mem_rd = 0; ex_mem_regwrite = 0; ex_mem_mem_read = 0;
        mem_wb_rd = 5; mem_wb_regwrite = 1;
        #1;
        total++;
        if ({b_hz, b_fwd, b_pc_stall, c_hz} !== {3'd0, 4'b0000, 1'b0, 3'd0}) begin
            bad++; $display("FAIL load_use_c3_run got=%b exp=%b", {b_hz, b_fwd, b_pc_stall, c_hz}, {3'd0, 4'b0000, 1'b0, 3'd0});
        end
        total++;
        if ({b_stall_cnt, a_stall_cnt, c_stall_cnt} !== {32'd2, 32'd1, 4'd2}) begin
            bad++; $display("FAIL load_use_counts got=%0d,%0d,%0d exp=2,1,2", b_stall_cnt, a_stall_cnt, c_stall_cnt);
        end
    endtask

    task automatic test_alu_forward();
        @(negedge clk);
        clear_inputs();
        id_ex_rd = 3; id_ex_regwrite = 1; ex_mem_rd = 3; ex_mem_regwrite = 1;
        id_rs = {5'd3, 5'd0}; id_rs_used = 2'b10;
        #1;
        total++;
        if ({a_fwd, a_pc_stall, a_hz, b_fwd} !== {4'b0100, 1'b0, 3'd0, 4'b0100}) begin
            bad++; $display("FAIL alu_fwd_nearest got=%b exp=%b", {a_fwd, a_pc_stall, a_hz, b_fwd}, {4'b0100, 1'b0, 3'd0, 4'b0100});
        end
        id_ex_regwrite = 0;
        #1;
        total++;
        if (a_fwd !== 4'b1000 || a_pc_stall !== 1'b0) begin
            bad++; $display("FAIL alu_fwd_exmem got=%b/%b exp=1000/0", a_fwd, a_pc_stall);
        end
        @(negedge clk);
        id_ex_rd = 0; id_ex_regwrite = 1; ex_mem_rd = 0; ex_mem_regwrite = 1;
        id_rs = {5'd0, 5'd0}; id_rs_used = 2'b11;
        #1;
        total++;
        if ({a_fwd, a_pc_stall, c_pc_stall} !== 6'b0) begin
            bad++; $display("FAIL alu_x0 got=%b exp=000000", {a_fwd, a_pc_stall, c_pc_stall});
        end
        @(negedge clk);
        id_ex_rd = 6; ex_mem_rd = 0; ex_mem_regwrite = 0;
        id_rs = {5'd0, 5'd6}; id_rs_used = 2'b10;
        #1;
        total++;
        if ({a_fwd, c_hz} !== 7'b0) begin
            bad++; $display("FAIL alu_unused_src got=%b exp=0000000", {a_fwd, c_hz});
        end
    endtask

    task automatic test_redirect();
        logic [63:0] fl0, fl1, st0;
        @(negedge clk);
        clear_inputs();
        id_ex_rd = 5; id_ex_regwrite = 1; id_ex_mem_read = 1;
        id_rs = {5'd0, 5'd5}; id_rs_used = 2'b01; ex_redirect = 1;
        #1;
        fl0 = flush_m[0];
        total++;
        if ({a_if_id_flush, a_id_ex_bubble, a_pc_stall, a_hz} !== {3'b110, 3'd2}) begin
            bad++; $display("FAIL redirect_over_data got=%b exp=%b", {a_if_id_flush, a_id_ex_bubble, a_pc_stall, a_hz}, {3'b110, 3'd2});
        end
        @(negedge clk);
        dmem_stall = 1;
        #1;
        total++;
        if ({32'd0, a_flush_cnt} !== fl0 + 1) begin
            bad++; $display("FAIL redirect_flush_cnt got=%0d exp=%0d", a_flush_cnt, fl0 + 1);
        end
        total++;
        if ({a_hz, a_if_id_flush, a_mem_wb_bubble, a_ex_mem_stall, a_id_ex_bubble} !== {3'd4, 4'b0110}) begin
            bad++; $display("FAIL redirect_under_mem got=%b exp=%b", {a_hz, a_if_id_flush, a_mem_wb_bubble, a_ex_mem_stall, a_id_ex_bubble}, {3'd4, 4'b0110});
        end
        fl1 = flush_m[0];
        st0 = stall_m[0];
        @(negedge clk);
        dmem_stall = 0; ex_busy = 1;
        #1;
        total++;
        if ({32'd0, a_flush_cnt} !== fl1 || {32'd0, a_stall_cnt} !== st0 + 1) begin
            bad++; $display("FAIL redirect_freeze_counts got=%0d/%0d exp=%0d/%0d", a_flush_cnt, a_stall_cnt, fl1, st0 + 1);
        end
        total++;
        if ({a_hz, a_ex_mem_bubble, a_if_id_flush, a_id_ex_stall} !== {3'd3, 3'b101}) begin
            bad++; $display("FAIL redirect_under_busy got=%b exp=%b", {a_hz, a_ex_mem_bubble, a_if_id_flush, a_id_ex_stall}, {3'd3, 3'b101});
        end
    endtask

    task automatic test_watchdog();
        @(negedge clk);
        clear_inputs();
        rst = 1;
        @(negedge clk);
        rst = 0; ex_busy = 1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (a_hang_err !== 1'b0) begin bad++; $display("FAIL wd_run3 got=%b exp=0", a_hang_err); end
        ex_busy = 0;
        @(negedge clk);
        #1;
        ex_busy = 1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (a_hang_err !== 1'b0) begin bad++; $display("FAIL wd_restart3 got=%b exp=0", a_hang_err); end
        @(negedge clk);
        #1;
        total++;
        if ({a_hang_err, b_hang_err, c_hang_err} !== 3'b100) begin
            bad++; $display("FAIL wd_fire got=%b exp=100", {a_hang_err, b_hang_err, c_hang_err});
        end
        ex_busy = 0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (a_hang_err !== 1'b1 || a_stall_cnt !== 32'd7) begin
            bad++; $display("FAIL wd_sticky got=%b/%0d exp=1/7", a_hang_err, a_stall_cnt);
        end
        ex_busy = 1; ex_redirect = 1; rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        total++;
        if ({a_hang_err, a_stall_cnt, a_flush_cnt, b_stall_cnt} !== 97'd0) begin
            bad++; $display("FAIL wd_rst_clear got=%h exp=0", {a_hang_err, a_stall_cnt, a_flush_cnt, b_stall_cnt});
        end
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (a_hang_err !== 1'b0) begin bad++; $display("FAIL wd_rst_midfreeze got=%b exp=0", a_hang_err); end
        @(negedge clk);
        #1;
        total++;
        if (a_hang_err !== 1'b1) begin bad++; $display("FAIL wd_refire got=%b exp=1", a_hang_err); end
        clear_inputs();
    endtask

    task automatic test_fwd_off();
        @(negedge clk);
        clear_inputs();
        ex_mem_rd = 7; ex_mem_regwrite = 1;
        id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
        #1;
        total++;
        if ({c_hz, c_pc_stall, c_fwd, a_fwd, a_hz} !== {3'd1, 1'b1, 4'b0000, 4'b0010, 3'd0}) begin
            bad++; $display("FAIL fwd_off_exmem got=%b exp=%b", {c_hz, c_pc_stall, c_fwd, a_fwd, a_hz}, {3'd1, 1'b1, 4'b0000, 4'b0010, 3'd0});
        end
        @(negedge clk);
        ex_mem_regwrite = 0; mem_wb_rd = 7; mem_wb_regwrite = 1;
        #1;
        total++;
        if ({c_hz, c_pc_stall, c_fwd} !== 8'b0) begin
            bad++; $display("FAIL fwd_off_memwb got=%b exp=00000000", {c_hz, c_pc_stall, c_fwd});
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        clear_inputs();
        rst = 1;
        @(negedge clk);
        rst = 0;
        ex_mem_rd = 9; ex_mem_regwrite = 1; id_rs = {5'd0, 5'd9}; id_rs_used = 2'b01;
        repeat (20) @(negedge clk);
        #1;
        total++;
        if ({c_stall_cnt, a_stall_cnt, c_hz} !== {4'hF, 32'd0, 3'd1}) begin
            bad++; $display("FAIL sat_stall got=%0d/%0d/%0d exp=15/0/1", c_stall_cnt, a_stall_cnt, c_hz);
        end
        ex_redirect = 1;
        repeat (18) @(negedge clk);
        #1;
        total++;
        if ({c_flush_cnt, c_stall_cnt, a_flush_cnt} !== {4'hF, 4'hF, 32'd18}) begin
            bad++; $display("FAIL sat_flush got=%0d/%0d/%0d exp=15/15/18", c_flush_cnt, c_stall_cnt, a_flush_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            id_rs           = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            id_rs_used      = 2'($urandom);
            id_ex_rd        = 5'($urandom_range(0, 3));
            ex_mem_rd       = 5'($urandom_range(0, 3));
            mem_wb_rd       = 5'($urandom_range(0, 3));
            id_ex_regwrite  = 1'($urandom);
            ex_mem_regwrite = 1'($urandom);
            mem_wb_regwrite = 1'($urandom);
            id_ex_mem_read  = 1'($urandom);
            ex_mem_mem_read = 1'($urandom);
            ex_busy         = (n < 200) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
            dmem_stall      = ($urandom_range(0, 7) == 0);
            ex_redirect     = ($urandom_range(0, 5) == 0);
            rst             = ($urandom_range(0, 99) == 0);
            #1;
            total++;
            if (a_comb !== exp_v[0]) begin bad++; $display("FAIL rand_comb_a n=%0d got=%b exp=%b", n, a_comb, exp_v[0]); end
            total++;
            if (b_comb !== exp_v[1]) begin bad++; $display("FAIL rand_comb_b n=%0d got=%b exp=%b", n, b_comb, exp_v[1]); end
            total++;
            if (c_comb !== exp_v[2]) begin bad++; $display("FAIL rand_comb_c n=%0d got=%b exp=%b", n, c_comb, exp_v[2]); end
            total++;
            if ({a_stall_cnt, a_flush_cnt, a_hang_err} !== {stall_m[0][31:0], flush_m[0][31:0], hang_m[0]}) begin
                bad++; $display("FAIL rand_regs_a n=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", n, a_stall_cnt, a_flush_cnt, a_hang_err, stall_m[0], flush_m[0], hang_m[0]);
            end
            total++;
            if ({b_stall_cnt, b_flush_cnt, b_hang_err} !== {stall_m[1][31:0], flush_m[1][31:0], hang_m[1]}) begin
                bad++; $display("FAIL rand_regs_b n=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", n, b_stall_cnt, b_flush_cnt, b_hang_err, stall_m[1], flush_m[1], hang_m[1]);
            end
            total++;
            if ({c_stall_cnt, c_flush_cnt, c_hang_err} !== {stall_m[2][3:0], flush_m[2][3:0], hang_m[2]}) begin
                bad++; $display("FAIL rand_regs_c n=%0d got=%0d/%0d/%b exp=%0d/%0d/%b", n, c_stall_cnt, c_flush_cnt, c_hang_err, stall_m[2], flush_m[2], hang_m[2]);
            end
        end
        @(negedge clk);
        clear_inputs();
        rst = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_load_use();
        test_alu_forward();
        test_redirect();
        test_watchdog();
        test_fwd_off();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32_hazard_ctrl.md
# rv32_hazard_ctrl

Parametrised hazard and forwarding controller for the rv32 five-stage pipeline. It supersedes the fixed two-source, stall-only hazard logic with the following additions:
- per-source forwarding selects;
- configurable load-use latency;
- a multi-cycle EX-unit busy freeze and a data-memory wait freeze;
- branch/jump redirect flush;
- saturating stall/flush performance counters and a freeze watchdog.

It sits beside the pipeline registers. The forward selects it computes in ID are captured into ID/EX by the pipeline.

## Interface
Parameters:
- REG_AW, 5, register address width
- NUM_SRC, 2, source operands per instruction (1..3)
- FWD_EN, 1, 1 = forward from EX/MEM and MEM/WB; 0 = stall on every RAW until producer reaches MEM/WB
- LOAD_LAT, 1, load-use bubbles (1 or 2); 2 = load data valid only in MEM/WB+1 path
- CNT_W, 32, performance counter width
- TIMEOUT, 1024, consecutive freeze cycles before hang_err; 0 disables

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_rs  in  NUM_SRC*REG_AW  ID source addresses, src k at [k*REG_AW +: REG_AW]
- id_rs_used  in  NUM_SRC  source k is read by ID instruction
- id_ex_rd, ex_mem_rd, mem_wb_rd  in  REG_AW  destination per stage
- id_ex_regwrite, ex_mem_regwrite, mem_wb_regwrite  in  1  stage writes rd
- id_ex_mem_read, ex_mem_mem_read  in  1  stage holds a load
- ex_busy  in  1  multi-cycle EX unit not done
- dmem_stall  in  1  data memory not ready
- ex_redirect  in  1  taken branch/jump resolved in EX
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1  hold register
- if_id_flush  out  1  squash IF/ID
- id_ex_bubble, ex_mem_bubble, mem_wb_bubble  out  1  load NOP into register
- forward_sel  out  2*NUM_SRC  per source: 00 FWD_NONE, 01 FWD_MEM, 10 FWD_WB
- hz_reason  out  3  0 RUN, 1 DATA, 2 FLUSH, 3 BUSY, 4 MEM
- stall_cnt, flush_cnt  out  CNT_W  performance counters
- hang_err  out  1  sticky watchdog flag

## Operation
Source match: src k matches a stage when all of the following hold:
- id_rs_used[k] = 1;
- rs ≠ 0;
- rs = the stage's rd;
- the stage's regwrite = 1.

Data hazard, any source:
- FWD_EN=1: the source matches id_ex with id_ex_mem_read=1, or (LOAD_LAT=2 and it matches ex_mem with ex_mem_mem_read=1).
- FWD_EN=0: the source matches id_ex or ex_mem.

Forwarding: applies only when FWD_EN=1 and that source has no hazard.
- id_ex match (non-load) → FWD_MEM.
- Else ex_mem match → FWD_WB.
- Else FWD_NONE.
- id_ex has priority over ex_mem.

Other forwarding rules:
- A mem_wb match needs no forward; the register file is write-through.
- FWD_EN=0 → all forward_sel = FWD_NONE.

Priority per cycle; the first matching row wins and all unlisted outputs are 0:
1. MEM (dmem_stall): pc/if_id/id_ex/ex_mem_stall=1, mem_wb_bubble=1.
2. BUSY (ex_busy): pc/if_id/id_ex_stall=1, ex_mem_bubble=1.
3. FLUSH (ex_redirect): if_id_flush=1, id_ex_bubble=1. This overrides any data hazard, because the ID instruction is squashed.
4. DATA: pc_stall=1, if_id_stall=1, id_ex_bubble=1.
5. RUN: nothing asserted.

forward_sel is computed in every state.

Counters:
- stall_cnt +1 each cycle pc_stall=1; flush_cnt +1 each cycle if_id_flush=1.
- Both saturate at all-ones.

Watchdog:
- An internal freeze counter +1 each cycle (dmem_stall|ex_busy); it clears to 0 on any cycle without freeze.
- When it reaches TIMEOUT, hang_err sets and stays set until rst.
- The freeze counter saturates at TIMEOUT.

## Timing
- Stall, bubble, flush, forward_sel and hz_reason are combinational from the inputs; they act in the same cycle, with zero latency, and are not gated by rst.
- Load-use costs exactly LOAD_LAT bubbles. This falls out naturally as the load advances; no internal state is needed.
- A redirect asserted during MEM/BUSY takes effect on the first unfrozen cycle. EX is held, so ex_redirect remains asserted.
- stall_cnt, flush_cnt, freeze counter and hang_err are registered and update at posedge clk.
- rst=1 at an edge: counters → 0, hang_err → 0, freeze counter → 0, regardless of other inputs, including mid-freeze.
- Simultaneous freeze and redirect: the freeze wins, if_id_flush=0, and the cycle counts in stall_cnt only.

## Test plan
- Load-use, LOAD_LAT=1. id_ex has lw x5 (regwrite=1, mem_read=1), id_rs0=5, used=1. Expect hz_reason=1, pc_stall=1, id_ex_bubble=1. Next cycle the load is in ex_mem: forward_sel[1:0]=10 and no stall. stall_cnt=1.
- Load-use, LOAD_LAT=2. Same stimulus → two DATA cycles; then the load is in mem_wb, forward_sel=00.
- ALU forward. id_ex add x3 and ex_mem add x3, id_rs1=3 → forward_sel[3:2]=01 (nearest producer). x0 with regwrite → 00, no stall.
- Redirect vs hazard. ex_redirect=1 with a load-use pending → if_id_flush=1, id_ex_bubble=1, pc_stall=0, flush_cnt +1. With dmem_stall also high → MEM state, no flush.
- Watchdog. TIMEOUT=4, ex_busy high 3 cycles, low 1, high 4 → hang_err rises after the 4th consecutive cycle and stays 1 after ex_busy drops. rst clears it and both counters to 0.
- FWD_EN=0. id_rs0 matches ex_mem non-load → DATA stall, forward_sel=00. A mem_wb match → RUN.
